// File: rtl/tipi_pkg.sv
// Shared types and constants for the TIPI Pi-side serializer.
// Frame length depends on PI_SHIFT_PARITY_EN (ninth odd-parity bit when defined).
package tipi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

`ifdef PI_SHIFT_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W           = 4;

  // Odd parity: the returned bit makes the total number of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/pi_shift_out_sync_edge.sv
// Multi-flop synchronizer plus history flop for one asynchronous Pi strobe;
// provides the synchronized level and a one-cycle rising-edge pulse.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/pi_shift_out.sv
// Pi-side serializer: loads the latched TIPI byte on a Pi load strobe and shifts
// it out MSB-first on the Pi serial clock. Build option: PI_SHIFT_PARITY_EN.
module pi_shift_out
  import tipi_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:7] din,
  input  logic       pi_le,
  input  logic       pi_sclk,
  output logic       pi_sdo,
  output logic       busy,
  output logic       taken
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);

  logic le_lvl, le_rise, sclk_lvl, sclk_rise;
  logic le_act, sclk_act;

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sdo_q, sdo_d;
  logic                    busy_q, busy_d;
  logic                    taken_q, taken_d;
  logic [FRAME_BITS-1:0]   load_word;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_le (
    .clk      (clk),
    .reset    (reset),
    .async_in (pi_le),
    .level    (le_lvl),
    .rise     (le_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk      (clk),
    .reset    (reset),
    .async_in (pi_sclk),
    .level    (sclk_lvl),
    .rise     (sclk_rise)
  );

  assign le_act   = le_rise & le_lvl;
  assign sclk_act = sclk_rise & sclk_lvl;

`ifdef PI_SHIFT_PARITY_EN
  assign load_word = {din, odd_parity(din)};
`else
  assign load_word = din;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sdo_d   = sdo_q;
    busy_d  = busy_q;
    taken_d = 1'b0;

    // A load always wins; a coincident sclk edge is dropped.
    if (le_act) begin
      shreg_d = load_word;
      cnt_d   = '0;
      sdo_d   = load_word[FRAME_BITS-1];
      busy_d  = 1'b1;
      state_d = ST_SHIFT;
    end else if (sclk_act && (state_q == ST_SHIFT)) begin
      shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
      cnt_d   = cnt_q + 1'b1;
      if (cnt_d == LAST_CNT) begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        taken_d = 1'b1;
        sdo_d   = 1'b0;
      end else begin
        sdo_d   = shreg_d[FRAME_BITS-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      taken_q <= taken_d;
    end
  end

  assign pi_sdo = sdo_q;
  assign busy   = busy_q;
  assign taken  = taken_q;

endmodule

// File: tb/tb_pi_shift_out.sv
// Self-checking bench for pi_shift_out: frame-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_pi_shift_out;

  localparam int S = 2;
`ifdef PI_SHIFT_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [0:7] din = '0;
  logic       pi_le = 1'b0;
  logic       pi_sclk = 1'b0;
  logic       pi_sdo, busy, taken;

  int n_chk = 0;
  int n_fail = 0;
  int taken_cnt = 0;
  bit chk_en = 1'b0;

  pi_shift_out #(.SYNC_STAGES(S)) dut (
    .clk     (clk),
    .reset   (reset),
    .din     (din),
    .pi_le   (pi_le),
    .pi_sclk (pi_sclk),
    .pi_sdo  (pi_sdo),
    .busy    (busy),
    .taken   (taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of bits; strobe edges take effect S clocks
  // after the pin is first seen high.
  logic       fb [0:8];
  int         m_idx = 0;
  bit         m_active = 0;
  logic       m_sdo = 0, m_busy = 0, m_taken = 0;
  logic [S-1:0] dl_le = '0, dl_sc = '0;
  logic       prev_le = 0, prev_sc = 0;

  always @(posedge clk) begin
    logic le_ev, sc_ev;
    if (reset) begin
      dl_le = '0; dl_sc = '0; prev_le = 0; prev_sc = 0;
      m_idx = 0; m_active = 0; m_sdo = 0; m_busy = 0; m_taken = 0;
    end else begin
      le_ev = dl_le[S-1];
      sc_ev = dl_sc[S-1];
      dl_le = {dl_le[S-2:0], pi_le & ~prev_le};
      dl_sc = {dl_sc[S-2:0], pi_sclk & ~prev_sc};
      prev_le = pi_le;
      prev_sc = pi_sclk;
      m_taken = 0;
      if (le_ev) begin
        for (int i = 0; i < 8; i++) fb[i] = din[i];
        fb[8] = ~^din;
        m_idx = 0; m_active = 1; m_busy = 1; m_sdo = fb[0];
      end else if (sc_ev && m_active) begin
        m_idx++;
        if (m_idx == FB) begin
          m_active = 0; m_busy = 0; m_taken = 1; m_sdo = 0;
        end else begin
          m_sdo = fb[m_idx];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pi_sdo", {8'd0, pi_sdo}, {8'd0, m_sdo});
      check("busy",   {8'd0, busy},   {8'd0, m_busy});
      check("taken",  {8'd0, taken},  {8'd0, m_taken});
      if (taken === 1'b1) taken_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_le(input logic [7:0] d, input int h);
    din = d; pi_le = 1'b1; cyc(h); pi_le = 1'b0; cyc(h);
  endtask

  task automatic pulse_sclk(input int h);
    pi_sclk = 1'b1; cyc(h); pi_sclk = 1'b0; cyc(h);
  endtask

  task automatic shift_n(input int n, output logic [8:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      cap = {cap[7:0], pi_sdo};
      pulse_sclk(S + 2);
    end
  endtask

  function automatic logic [8:0] frame_of(input logic [7:0] d);
    return (FB == 9) ? {d, ~^d} : {1'b0, d};
  endfunction

  logic [8:0] cap;

  initial begin
    reset = 1'b1; cyc(3); reset = 1'b0;
    chk_en = 1'b1;
    check("reset_sdo",   {8'd0, pi_sdo}, 9'd0);
    check("reset_busy",  {8'd0, busy},   9'd0);
    check("reset_taken", {8'd0, taken},  9'd0);
    pulse_sclk(S + 2); pulse_sclk(S + 2);
    check("idle_sclk_sdo",  {8'd0, pi_sdo}, 9'd0);
    check("idle_sclk_busy", {8'd0, busy},   9'd0);

    // AA frame
    taken_cnt = 0;
    pulse_le(8'hAA, S + 2);
    check("aa_busy", {8'd0, busy}, 9'd1);
    shift_n(FB, cap);
    check("aa_bits", cap, frame_of(8'hAA));
`ifdef PI_SHIFT_PARITY_EN
    check("aa_parity_bit", {8'd0, cap[0]}, 9'd1);
`endif
    check("aa_taken_cnt", 9'(taken_cnt), 9'd1);
    check("aa_done_busy", {8'd0, busy}, 9'd0);
    check("aa_done_sdo",  {8'd0, pi_sdo}, 9'd0);
    pulse_sclk(S + 2);
    check("done_sclk_sdo", {8'd0, pi_sdo}, 9'd0);
    check("done_sclk_taken_cnt", 9'(taken_cnt), 9'd1);

    // C3 with din changed after load
    taken_cnt = 0;
    pulse_le(8'hC3, S + 2);
    din = 8'h00;
    shift_n(FB, cap);
    check("c3_bits", cap, frame_of(8'hC3));
    check("c3_taken_cnt", 9'(taken_cnt), 9'd1);

    // Abort FF after 3 bits by reloading 01
    taken_cnt = 0;
    pulse_le(8'hFF, S + 2);
    shift_n(3, cap);
    check("ff_partial", cap, 9'b000000111);
    pulse_le(8'h01, S + 2);
    check("reload_taken_cnt", 9'(taken_cnt), 9'd0);
    shift_n(FB, cap);
    check("01_bits", cap, frame_of(8'h01));
    check("01_taken_cnt", 9'(taken_cnt), 9'd1);

    // Reset mid-frame
    taken_cnt = 0;
    pulse_le(8'hAA, S + 2);
    shift_n(4, cap);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("midrst_sdo",  {8'd0, pi_sdo}, 9'd0);
    check("midrst_busy", {8'd0, busy},   9'd0);
    pulse_sclk(S + 2); pulse_sclk(S + 2);
    check("midrst_sclk_sdo", {8'd0, pi_sdo}, 9'd0);
    check("midrst_taken_cnt", 9'(taken_cnt), 9'd0);

    // Load and sclk edges together: load wins
    taken_cnt = 0;
    pulse_le(8'hF0, S + 2);
    shift_n(2, cap);
    din = 8'h5A; pi_le = 1'b1; pi_sclk = 1'b1;
    cyc(S + 2);
    pi_le = 1'b0; pi_sclk = 1'b0;
    cyc(S + 2);
    shift_n(FB, cap);
    check("coincident_bits", cap, frame_of(8'h5A));
    check("coincident_taken_cnt", 9'(taken_cnt), 9'd1);

`ifdef PI_SHIFT_PARITY_EN
    pulse_le(8'h07, S + 2);
    shift_n(FB, cap);
    check("07_parity_bit", {8'd0, cap[0]}, 9'd0);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op < 4) begin
        pulse_le(8'($urandom), $urandom_range(S + 2, S + 5));
      end else if (op < 19) begin
        pulse_sclk($urandom_range(S + 2, S + 5));
      end else begin
        reset = 1'b1; cyc($urandom_range(1, 3)); reset = 1'b0;
      end
    end
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
